// File: rtl/spi_flash_fetch_if.sv
// -----------------------------------------------------------------------------
// spi_flash_fetch_if
//   Word-fetch request/response bundle between a requester (DMA / instruction
//   register path) and the SPI flash fetch engine.
//
//   rd_req    requester -> engine  request strobe, taken when rd_req && !rd_busy
//   rd_addr   requester -> engine  24-bit byte address (bits [1:0] ignored)
//   rd_busy   engine -> requester  transaction in progress / request not taken
//   rd_valid  engine -> requester  one-cycle pulse, rd_data holds a new word
//   rd_data   engine -> requester  fetched 32-bit word, held until next rd_valid
//
//   master : requester side
//   slave  : fetch engine side
// -----------------------------------------------------------------------------
interface spi_flash_fetch_if;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_busy;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_busy,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_busy,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/spi_flash_fetch.sv
// -----------------------------------------------------------------------------
// spi_flash_fetch
//   Reads one 32-bit little-endian word from an external SPI NOR flash per
//   request (SPI mode 0, MSB first) and returns it over a busy/valid handshake.
//   Frame: CMD(8) -> ADDR(24) -> [DUMMY(8)] -> DATA(32), then chip select is
//   held high for CS_IDLE cycles before the next frame can start.
//
//   Build option: define FLASH_FAST_READ_EN to use FAST READ (0x0B) with
//   8 dummy SCK cycles; otherwise plain READ (0x03) without dummy cycles.
//
// Parameters
//   CLK_DIV    clk cycles per SCK half-period (>=1)
//   ADDR_BASE  byte offset added (mod 2^24) to the request address
//   CS_IDLE    clk cycles flash_cs is high between back-to-back frames (>=1)
//
// Ports
//   clk         system clock, everything on posedge
//   resetn      synchronous active-low reset
//   rd          request/response bundle (slave modport)
//   flash_clk   SPI SCK, idles low
//   flash_cs    SPI chip select, active low
//   flash_mosi  SPI data to flash
//   flash_miso  SPI data from flash
// -----------------------------------------------------------------------------
module spi_flash_fetch #(
  parameter int          CLK_DIV   = 2,
  parameter logic [23:0] ADDR_BASE = 24'h0,
  parameter int          CS_IDLE   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  spi_flash_fetch_if.slave        rd,
  output logic                    flash_clk,
  output logic                    flash_cs,
  output logic                    flash_mosi,
  input  logic                    flash_miso
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam logic [7:0] CMD = 8'h03;
`endif

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int              GAP_W    = $clog2(CS_IDLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_FINISH,
    S_GAP
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic               valid_q;
  logic [31:0]        data_q;
  logic               cs_q;
  logic               sck_q;
  logic               mosi_q;
  logic [DIV_W-1:0]   div_q;
  logic [4:0]         bit_q;
  logic [GAP_W-1:0]   gap_q;
  logic [31:0]        tx_q;
  logic [31:0]        rx_q;
  logic [23:0]        addr_d;

  // Bytes arrive first-byte-first, each MSB first, so after 32 shifts byte 0
  // sits in the top of the shift register; it belongs in the LSB of the word.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Word-aligned, offset address; the 24-bit add wraps naturally.
  assign addr_d = ADDR_BASE + (rd.rd_addr & 24'hFFFFFC);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd.rd_req) begin
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= CMD[7];
            // Remaining command bits followed by the address, MSB first.
            tx_q    <= {CMD[6:0], addr_d, 1'b0};
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_CMD;
          end
        end

        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sck_q) begin
              // Rising edge: flash data is stable here.
              sck_q <= 1'b1;
              if (state_q == S_DATA) begin
                rx_q <= {rx_q[30:0], flash_miso};
              end
            end else begin
              // Falling edge: bit finished, present the next MOSI bit.
              sck_q <= 1'b0;
              bit_q <= bit_q + 5'd1;
              if (state_q == S_CMD || (state_q == S_ADDR && bit_q != 5'd23)) begin
                mosi_q <= tx_q[31];
                tx_q   <= {tx_q[30:0], 1'b0};
              end else begin
                mosi_q <= 1'b0;
              end
              case (state_q)
                S_CMD: begin
                  if (bit_q == 5'd7) begin
                    bit_q   <= '0;
                    state_q <= S_ADDR;
                  end
                end
                S_ADDR: begin
                  if (bit_q == 5'd23) begin
                    bit_q   <= '0;
`ifdef FLASH_FAST_READ_EN
                    state_q <= S_DUMMY;
`else
                    state_q <= S_DATA;
`endif
                  end
                end
                S_DUMMY: begin
                  if (bit_q == 5'd7) begin
                    bit_q   <= '0;
                    state_q <= S_DATA;
                  end
                end
                S_DATA: begin
                  if (bit_q == 5'd31) begin
                    bit_q   <= '0;
                    state_q <= S_FINISH;
                  end
                end
                default: ;
              endcase
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_FINISH: begin
          cs_q    <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          valid_q <= 1'b1;
          data_q  <= swap_bytes(rx_q);
          // The completion cycle already counts as a chip-select-high cycle,
          // and so does the idle cycle in which the next request is taken.
          if (CS_IDLE <= 1) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q   <= GAP_W'(CS_IDLE - 2);
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cs_q    <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd.rd_busy  = busy_q;
  assign rd.rd_valid = valid_q;
  assign rd.rd_data  = data_q;
  assign flash_clk   = sck_q;
  assign flash_cs    = cs_q;
  assign flash_mosi  = mosi_q;

endmodule
